// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one instruction-fetch port and one load/store port
// share a single fixed-latency memory. Conflicts alternate between the ports.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_ack,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    // Counter holds remaining ACCESS cycles minus one; MEM_LAT is at most 15.
    localparam logic [3:0] CntInit = 4'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_data_q, last_data_d;  // 1: last grant went to data port
    logic              gnt_data_q, gnt_data_d;    // 1: current owner is data port
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              pick_data;

    // Next-state, grant decision and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_data_d  = last_data_q;
        gnt_data_d   = gnt_data_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        pick_data    = 1'b0;
        inst_ack     = 1'b0;
        data_ack     = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        unique case (state_q)
            StIdle: begin
                if (inst_req || data_req) begin
                    // On conflict, favour whichever port was not served last.
                    pick_data   = data_req && (!inst_req || !last_data_q);
                    gnt_data_d  = pick_data;
                    last_data_d = pick_data;
                    if (pick_data) begin
                        addr_d  = data_addr;
                        we_d    = data_we;
                        wdata_d = data_wdata;
                    end else begin
                        addr_d  = inst_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                    cnt_d   = CntInit;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                mem_en    = 1'b1;
                mem_we    = gnt_data_q && we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (cnt_q == 4'd0) begin
                    if (!gnt_data_q) begin
                        inst_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        data_rdata_d = mem_rdata;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                inst_ack = !gnt_data_q;
                data_ack = gnt_data_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy       = (state_q != StIdle);
        inst_rdata = inst_rdata_q;
        data_rdata = data_rdata_q;
    end

    // State registers with synchronous reset; reset aborts any transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            last_data_q  <= 1'b0;
            gnt_data_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_data_q  <= last_data_d;
            gnt_data_q   <= gnt_data_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table on a MEM_LAT=2
// instance, plus hand-written conflict and MEM_LAT=1 back-to-back sequences.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        inst_req;
    logic [63:0] inst_addr;
    logic        data_req;
    logic        data_we;
    logic [63:0] data_addr;
    logic [63:0] data_wdata;
    logic [63:0] mem_rdata;

    logic        inst_ack, data_ack, mem_en, mem_we, busy;
    logic [63:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic        inst_ack1, data_ack1, mem_en1, mem_we1, busy1;
    logic [63:0] inst_rdata1, data_rdata1, mem_addr1, mem_wdata1;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .inst_req  (inst_req),
        .inst_addr (inst_addr),
        .inst_ack  (inst_ack),
        .inst_rdata(inst_rdata),
        .data_req  (data_req),
        .data_we   (data_we),
        .data_addr (data_addr),
        .data_wdata(data_wdata),
        .data_ack  (data_ack),
        .data_rdata(data_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_dut1 (
        .clock     (clock),
        .reset     (reset),
        .inst_req  (inst_req),
        .inst_addr (inst_addr),
        .inst_ack  (inst_ack1),
        .inst_rdata(inst_rdata1),
        .data_req  (data_req),
        .data_we   (data_we),
        .data_addr (data_addr),
        .data_wdata(data_wdata),
        .data_ack  (data_ack1),
        .data_rdata(data_rdata1),
        .mem_en    (mem_en1),
        .mem_we    (mem_we1),
        .mem_addr  (mem_addr1),
        .mem_wdata (mem_wdata1),
        .mem_rdata (mem_rdata),
        .busy      (busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [63:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [63:0] daddr;
        logic [63:0] dwd;
        logic [63:0] mrd;
        logic        e_iack;
        logic        e_dack;
        logic        e_en;
        logic        e_we;
        logic [63:0] e_maddr;
        logic [63:0] e_mwd;
        logic        e_busy;
        logic [63:0] e_ird;
        logic [63:0] e_drd;
    } vec_t;

    localparam int NVec = 26;
    localparam logic [63:0] IR = 64'h00A0_0093;
    localparam logic [63:0] BF = 64'hDEAD_BEEF;
    vec_t vecs[NVec];

    function automatic vec_t mk(
        input logic rst, ireq, input logic [63:0] iaddr,
        input logic dreq, dwe, input logic [63:0] daddr, dwd, mrd,
        input logic e_iack, e_dack, e_en, e_we, input logic [63:0] e_maddr, e_mwd,
        input logic e_busy, input logic [63:0] e_ird, e_drd);
        vec_t v;
        v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
        v.daddr = daddr; v.dwd = dwd; v.mrd = mrd; v.e_iack = e_iack; v.e_dack = e_dack;
        v.e_en = e_en; v.e_we = e_we; v.e_maddr = e_maddr; v.e_mwd = e_mwd;
        v.e_busy = e_busy; v.e_ird = e_ird; v.e_drd = e_drd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, ireq, input logic [63:0] iaddr,
                         input logic dreq, dwe, input logic [63:0] daddr, dwd, mrd);
        reset = rst; inst_req = ireq; inst_addr = iaddr; data_req = dreq;
        data_we = dwe; data_addr = daddr; data_wdata = dwd; mem_rdata = mrd;
    endtask

    initial begin
        //               rst ireq iaddr dreq we daddr   wdata  mrdata
        //               iack dack en we maddr  mwdata  busy  irdata dr
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 64'h40, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, IR,          0, 0, 1, 0, 64'h40, 0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, IR,          0, 0, 1, 0, 64'h40, 0, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,           1, 0, 0, 0, 0, 0, 1, IR, 0);
        vecs[5]  = mk(0, 0, 0, 1, 1, 64'h100, BF, 0,    0, 0, 0, 0, 0, 0, 0, IR, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 64'h1234,    0, 0, 1, 1, 64'h100, BF, 1, IR, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 64'h1234,    0, 0, 1, 1, 64'h100, BF, 1, IR, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 1, 0, 0, 0, 0, 1, IR, 0);
        vecs[9]  = mk(0, 0, 0, 1, 0, 64'h200, 64'h77, 0, 0, 0, 0, 0, 0, 0, 0, IR, 0);
        vecs[10] = mk(0, 0, 0, 1, 1, 64'h999, 64'h88, 64'hCAFE,
                      0, 0, 1, 0, 64'h200, 64'h77, 1, IR, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 64'hCAFE,
                      0, 0, 1, 0, 64'h200, 64'h77, 1, IR, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 1, 0, 0, 0, 0, 1, IR, 64'hCAFE);
        vecs[13] = mk(0, 1, 64'h80, 1, 0, 64'h300, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, IR, 64'hCAFE);
        vecs[14] = mk(0, 1, 64'h80, 1, 0, 64'h300, 0, 64'hAA,
                      0, 0, 1, 0, 64'h80, 0, 1, IR, 64'hCAFE);
        vecs[15] = mk(0, 1, 64'h80, 1, 0, 64'h300, 0, 64'hAA,
                      0, 0, 1, 0, 64'h80, 0, 1, IR, 64'hCAFE);
        vecs[16] = mk(0, 1, 64'h80, 1, 0, 64'h300, 0, 0,
                      1, 0, 0, 0, 0, 0, 1, 64'hAA, 64'hCAFE);
        vecs[17] = mk(0, 1, 64'h80, 1, 0, 64'h300, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 64'hAA, 64'hCAFE);
        vecs[18] = mk(0, 1, 64'h80, 1, 0, 64'h300, 0, 64'hBB,
                      0, 0, 1, 0, 64'h300, 0, 1, 64'hAA, 64'hCAFE);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 64'hBB,
                      0, 0, 1, 0, 64'h300, 0, 1, 64'hAA, 64'hCAFE);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 1, 0, 0, 0, 0, 1, 64'hAA, 64'hBB);
        vecs[21] = mk(0, 0, 0, 1, 1, 64'h104, 64'h11, 0,
                      0, 0, 0, 0, 0, 0, 0, 64'hAA, 64'hBB);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 1, 1, 64'h104, 64'h11, 1, 64'hAA, 64'hBB);
        // Reset asserted during the second ACCESS cycle of the store.
        vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 1, 1, 64'h104, 64'h11, 1, 64'hAA, 64'hBB);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);

        // Table: vector i drives cycle i; outputs checked mid-cycle.
        for (int i = 0; i < NVec; i++) begin
            @(posedge clock);
            #1;
            drive(vecs[i].rst, vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe,
                  vecs[i].daddr, vecs[i].dwd, vecs[i].mrd);
            @(negedge clock);
            check($sformatf("v%0d inst_ack", i), inst_ack, vecs[i].e_iack);
            check($sformatf("v%0d data_ack", i), data_ack, vecs[i].e_dack);
            check($sformatf("v%0d mem_en", i), mem_en, vecs[i].e_en);
            check($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_we);
            check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
            check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mwd);
            check($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
            check($sformatf("v%0d inst_rdata", i), inst_rdata, vecs[i].e_ird);
            check($sformatf("v%0d data_rdata", i), data_rdata, vecs[i].e_drd);
        end

        // Conflict right after reset with both requests held: data, inst, data.
        @(posedge clock);
        #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 12; c++) begin
            @(posedge clock);
            #1;
            drive(0, 1, 64'h500, 1, 0, 64'h600, 0, 64'h5);
            @(negedge clock);
            check($sformatf("conflict c%0d data_ack", c), data_ack, (c == 3 || c == 11));
            check($sformatf("conflict c%0d inst_ack", c), inst_ack, (c == 7));
            check($sformatf("conflict c%0d busy", c), busy, (c % 4 != 0));
        end

        // MEM_LAT=1 back-to-back fetches: one ACCESS cycle, ack every third cycle.
        @(posedge clock);
        #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 9; c++) begin
            @(posedge clock);
            #1;
            drive(0, 1, 64'h700, 0, 0, 0, 0, 64'h9);
            @(negedge clock);
            check($sformatf("lat1 c%0d inst_ack", c), inst_ack1, (c % 3 == 2));
            check($sformatf("lat1 c%0d mem_en", c), mem_en1, (c % 3 == 1));
            check($sformatf("lat1 c%0d mem_addr", c), mem_addr1,
                  (c % 3 == 1) ? 64'h700 : 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
